sram_word_bridge: RTL

- Upstream front-end for the FIFO-based SPI SRAM controller. It turns single word requests (1–4 bytes, valid/ready) into that controller's byte-FIFO protocol.
- Write path: pushes bytes in, issues write_cmd, waits for the busy cycle.
- Read path: issues read_cmd, waits for busy to fall, then drains the FIFO and assembles a little-endian word.
- Sits between a CPU/bus master and the SPI SRAM controller; one request outstanding at a time.

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_word_bridge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SPI SRAM controller and its word bridge:
// bridge state encoding, SRAM opcodes and the request-length helper.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PUSH      = 3'd1,
        CMD       = 3'd2,
        WAIT_RISE = 3'd3,
        WAIT_FALL = 3'd4,
        POP       = 3'd5,
        RESP      = 3'd6
    } state_t;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_QUAD  = 8'h38;

    // req_len encodes byte count minus one.
    function automatic logic [2:0] byte_count(input logic [1:0] len);
        return {1'b0, len} + 3'd1;
    endfunction

endpackage

// File: rtl/sram_word_bridge.sv
// Word-request front-end for the FIFO-based SPI SRAM controller: pushes write
// bytes, issues commands, waits out busy and assembles little-endian read words.
module sram_word_bridge
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [1:0]                    req_len,
    input  logic [31:0]                   req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_rdata,
    output logic                          rsp_err,
    input  logic                          mem_busy,
    output logic [7:0]                    mem_data_in,
    output logic                          mem_data_in_valid,
    input  logic [7:0]                    mem_data_out,
    output logic                          mem_data_out_read,
    output logic                          mem_write_cmd,
    output logic                          mem_read_cmd,
    output logic [$clog2(FIFO_DEPTH):0]   mem_read_cmd_size,
    output logic [ADDR_WIDTH-1:0]         mem_address
);

    localparam int SIZE_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state, state_nxt;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              len_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    err_q;
    logic [1:0]              cnt_q;
    logic [TMR_W-1:0]        tmr_q;
    logic                    accept;
    logic                    timeout_hit;
    logic                    timed_out;

    assign timed_out = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path
        // through the case statement can infer a latch.
        state_nxt         = state;
        accept            = 1'b0;
        timeout_hit       = 1'b0;
        req_ready         = 1'b0;
        rsp_valid         = 1'b0;
        rsp_rdata         = '0;
        rsp_err           = 1'b0;
        mem_data_in       = '0;
        mem_data_in_valid = 1'b0;
        mem_data_out_read = 1'b0;
        mem_write_cmd     = 1'b0;
        mem_read_cmd      = 1'b0;
        mem_read_cmd_size = '0;
        mem_address       = '0;

        case (state)
            IDLE: begin
                req_ready = !mem_busy && !rst;
                accept    = req_valid && req_ready;
                if (accept) state_nxt = req_write ? PUSH : CMD;
            end
            PUSH: begin
                mem_data_in_valid = 1'b1;
                mem_data_in       = wdata_q[{cnt_q, 3'b000} +: 8];
                if (cnt_q == len_q) state_nxt = CMD;
            end
            CMD: begin
                mem_write_cmd     = wr_q;
                mem_read_cmd      = !wr_q;
                mem_address       = addr_q;
                mem_read_cmd_size = SIZE_W'(byte_count(len_q));
                state_nxt         = WAIT_RISE;
            end
            WAIT_RISE: begin
                mem_address = addr_q;
                if (mem_busy) begin
                    state_nxt = WAIT_FALL;
                end else if (timed_out) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RESP;
                end
            end
            WAIT_FALL: begin
                mem_address = addr_q;
                if (!mem_busy) begin
                    state_nxt = wr_q ? RESP : POP;
                end else if (timed_out) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RESP;
                end
            end
            POP: begin
                mem_data_out_read = 1'b1;
                if (cnt_q == len_q) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state <= state_nxt;

            // Byte counter and timer both restart on every state change.
            if (state_nxt != state)                        cnt_q <= '0;
            else if (state == PUSH || state == POP)        cnt_q <= cnt_q + 2'd1;

            if (state_nxt != state)                          tmr_q <= '0;
            else if (state == WAIT_RISE || state == WAIT_FALL) tmr_q <= tmr_q + 1'b1;

            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                len_q   <= req_len;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end

            if (state == POP) rdata_q[{cnt_q, 3'b000} +: 8] <= mem_data_out;
            if (timeout_hit)  err_q <= 1'b1;
        end
    end

endmodule
